// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM request front-end.
package sram_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_req_fifo.sv
// Synchronous request FIFO; full/empty come from the occupancy count.
module sram_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[rd_ptr];

    // Entry storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_sequencer.sv
// Turns a valid/ready request stream into single-cycle SRAM controller
// command pulses and returns read data on a valid/ready response channel.
module sram_req_sequencer
    import sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = sram_pkg::ADDR_W,
    parameter int DATA_W     = sram_pkg::DATA_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            mem_write,
    output logic                            mem_read,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    state_t             state;
    state_t             next_state;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    assign req_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state != IDLE);
    assign head_write = head[ENTRY_W-1];
    assign head_addr  = head[DATA_W +: ADDR_W];
    assign head_wdata = head[DATA_W-1:0];

    sram_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data ({req_write, req_addr, req_wdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pop decision; the issued command type steers ISSUE's exit.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = mem_read ? CAPTURE : IDLE;
            CAPTURE: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command pulses, held address/data, and the captured read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            if (pop) begin
                mem_write <= head_write;
                mem_read  <= !head_write;
                mem_addr  <= head_addr;
                if (head_write) begin
                    mem_wdata <= head_wdata;
                end
            end
            if (state == CAPTURE) begin
                rsp_rdata <= mem_rdata;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Directed bench for sram_req_sequencer with a behavioural SRAM controller.
module tb_sram_req_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       mem_write;
    logic       mem_read;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       busy;
    logic [2:0] level;

    logic [7:0] sram [8];

    int checks = 0;
    int fails  = 0;

    sram_req_sequencer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (3),
        .DATA_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Controller model: samples commands at the edge, registers read data.
    always @(posedge clk) begin
        if (mem_write) sram[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= sram[mem_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic [2:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, mem_write, mem_read, mem_addr, mem_wdata, busy, level} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0}) begin
            fails++;
            $display("[TB] FAIL reset_values: got rdy=%b rv=%b rd=%h w=%b r=%b a=%h wd=%h busy=%b lvl=%0d, want rdy=1 others 0",
                     req_ready, rsp_valid, rsp_rdata, mem_write, mem_read, mem_addr, mem_wdata, busy, level);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, level, mem_write, mem_read} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got busy=%b lvl=%0d w=%b r=%b, want 0 0 0 0", busy, level, mem_write, mem_read);
        end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        drive_req(1'b1, 3'd3, 8'hA5);
        tick();
        req_valid = 1'b0;
        checks++;
        if (level !== 3'd1 || mem_write !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wr_accept: got lvl=%0d w=%b, want lvl=1 w=0", level, mem_write);
        end
        tick();
        checks++;
        if ({mem_write, mem_read, mem_addr, mem_wdata, level, busy} !== {1'b1, 1'b0, 3'd3, 8'hA5, 3'd0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL wr_pulse: got w=%b r=%b a=%0d wd=%h lvl=%0d busy=%b, want 1 0 3 a5 0 1",
                     mem_write, mem_read, mem_addr, mem_wdata, level, busy);
        end
        tick();
        checks++;
        if ({mem_write, busy, mem_addr, mem_wdata} !== {1'b0, 1'b0, 3'd3, 8'hA5}) begin
            fails++;
            $display("[TB] FAIL wr_done: got w=%b busy=%b a=%0d wd=%h, want 0 0 3 a5", mem_write, busy, mem_addr, mem_wdata);
        end
        drive_req(1'b0, 3'd3, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if ({mem_read, mem_write, mem_addr, rsp_valid} !== {1'b1, 1'b0, 3'd3, 1'b0}) begin
            fails++;
            $display("[TB] FAIL rd_pulse: got r=%b w=%b a=%0d rv=%b, want 1 0 3 0", mem_read, mem_write, mem_addr, rsp_valid);
        end
        tick();
        checks++;
        if (mem_read !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rd_capture: got r=%b rv=%b, want 0 0", mem_read, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL rd_latency: got rv=%b rd=%h, want rv=1 rd=a5", rsp_valid, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rd_handshake: got rv=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        drive_req(1'b0, 3'd3, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 3'(i), 8'h10 + 8'(i));
            tick();
        end
        checks++;
        if (level !== 3'd4 || req_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_flag: got lvl=%0d rdy=%b, want 4 0", level, req_ready);
        end
        drive_req(1'b1, 3'd5, 8'hEE);
        tick();
        req_valid = 1'b0;
        checks++;
        if (level !== 3'd4 || rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL push_when_full: got lvl=%0d rv=%b rd=%h, want 4 1 a5", level, rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || mem_write !== 1'b0 || level !== 3'd4) begin
            fails++;
            $display("[TB] FAIL b2b_handshake: got rv=%b w=%b lvl=%0d, want 0 0 4", rsp_valid, mem_write, level);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_write, mem_read, mem_addr, mem_wdata, level, req_ready} !==
                {1'b1, 1'b0, 3'(i), 8'h10 + 8'(i), 3'(3 - i), 1'b1}) begin
                fails++;
                $display("[TB] FAIL b2b_pulse%0d: got w=%b r=%b a=%0d wd=%h lvl=%0d rdy=%b, want 1 0 %0d %h %0d 1",
                         i, mem_write, mem_read, mem_addr, mem_wdata, level, req_ready, i, 8'h10 + 8'(i), 3 - i);
            end
            tick();
            checks++;
            if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
                fails++;
                $display("[TB] FAIL b2b_gap%0d: got w=%b r=%b, want 0 0", i, mem_write, mem_read);
            end
            if (i < 3) tick();
        end
        checks++;
        if (level !== 3'd0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_drain: got lvl=%0d busy=%b, want 0 0", level, busy);
        end
    endtask

    task automatic test_resp_stall();
        rsp_ready = 1'b0;
        drive_req(1'b1, 3'd7, 8'h7E);
        tick();
        drive_req(1'b0, 3'd7, 8'h00);
        tick();
        drive_req(1'b1, 3'd0, 8'h55);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h7E || level !== 3'd1) begin
            fails++;
            $display("[TB] FAIL stall_resp: got rv=%b rd=%h lvl=%0d, want 1 7e 1", rsp_valid, rsp_rdata, level);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_rdata, mem_write, mem_read, level} !== {1'b1, 8'h7E, 1'b0, 1'b0, 3'd1}) begin
                fails++;
                $display("[TB] FAIL stall_hold%0d: got rv=%b rd=%h w=%b r=%b lvl=%0d, want 1 7e 0 0 1",
                         c, rsp_valid, rsp_rdata, mem_write, mem_read, level);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_release: got rv=%b w=%b, want 0 0", rsp_valid, mem_write);
        end
        tick();
        checks++;
        if ({mem_write, mem_addr, mem_wdata, level} !== {1'b1, 3'd0, 8'h55, 3'd0}) begin
            fails++;
            $display("[TB] FAIL stall_queued_wr: got w=%b a=%0d wd=%h lvl=%0d, want 1 0 55 0", mem_write, mem_addr, mem_wdata, level);
        end
        tick();
    endtask

    task automatic test_simul_push_pop();
        rsp_ready = 1'b0;
        drive_req(1'b0, 3'd7, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        drive_req(1'b1, 3'd1, 8'h31);
        tick();
        drive_req(1'b1, 3'd2, 8'h32);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (level !== 3'd2 || rsp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pp_setup: got lvl=%0d rv=%b, want 2 0", level, rsp_valid);
        end
        drive_req(1'b1, 3'd4, 8'h34);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({level, req_ready, mem_write, mem_addr, mem_wdata} !== {3'd2, 1'b1, 1'b1, 3'd1, 8'h31}) begin
            fails++;
            $display("[TB] FAIL pp_level: got lvl=%0d rdy=%b w=%b a=%0d wd=%h, want 2 1 1 1 31",
                     level, req_ready, mem_write, mem_addr, mem_wdata);
        end
        for (int c = 0; c < 20 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            fails++;
            $display("[TB] FAIL pp_drain: got busy=%b lvl=%0d, want 0 0", busy, level);
        end
    endtask

    task automatic test_wraparound();
        logic [7:0] exp_q[$];
        int         got = 0;
        int         sent = 0;
        rsp_ready = 1'b1;
        fork
            begin
                int guard = 0;
                while (sent < 20 && guard < 250) begin
                    int         idx;
                    logic       w;
                    logic       acc;
                    logic [7:0] d;
                    idx = sent / 2;
                    w = (sent % 2 == 0);
                    d = 8'(idx * 37 + 5);
                    req_valid = 1'($urandom_range(0, 1));
                    req_write = w;
                    req_addr  = 3'((idx * 3) % 8);
                    req_wdata = d;
                    acc = req_valid && req_ready;
                    if (acc && !w) exp_q.push_back(d);
                    tick();
                    guard++;
                    if (acc) sent++;
                end
                req_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 320; c++) begin
                    tick();
                    if (rsp_valid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL wrap_extra: got unexpected response %h, want none", rsp_rdata);
                        end else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            if (rsp_rdata !== e) begin
                                fails++;
                                $display("[TB] FAIL wrap_data%0d: got %h, want %h", got, rsp_rdata, e);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 10 || sent != 20 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL wrap_count: got responses=%0d sent=%0d left=%0d, want 10 20 0", got, sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        drive_req(1'b0, 3'd2, 8'h00);
        tick();
        drive_req(1'b1, 3'd4, 8'h44);
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_read !== 1'b1 || level !== 3'd1) begin
            fails++;
            $display("[TB] FAIL rst_pre: got r=%b lvl=%0d, want 1 1", mem_read, level);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, rsp_valid, level, busy} !== {1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL rst_async: got r=%b w=%b rv=%b lvl=%0d busy=%b, want all 0",
                     mem_read, mem_write, rsp_valid, level, busy);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({rsp_valid, mem_write, mem_read, busy} !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL rst_quiet%0d: got rv=%b w=%b r=%b busy=%b, want 0 0 0 0",
                         c, rsp_valid, mem_write, mem_read, busy);
            end
        end
        drive_req(1'b1, 3'd2, 8'h3C);
        tick();
        drive_req(1'b0, 3'd2, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin
            fails++;
            $display("[TB] FAIL rst_recover: got rv=%b rd=%h, want 1 3c", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) sram[i] = 8'h00;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_resp_stall();
        test_simul_push_pop();
        test_wraparound();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
